// File: rtl/gfx_line_compositor.sv
// Per-pixel layer compositor: priority selection, colour effects, and a
// ping-pong scanline buffer drained over a valid/ready output handshake.
module gfx_line_compositor #(
  parameter int NUM_LAYERS = 6,
  parameter int LINE_WIDTH = 240,
  parameter int COLOR_W    = 15
) (
  input  logic                            clock,
  input  logic                            rst_b,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LAYERS*COLOR_W-1:0]   layer_color,
  input  logic [NUM_LAYERS*2-1:0]         layer_prio,
  input  logic [NUM_LAYERS-1:0]           layer_opaque,
  input  logic [COLOR_W-1:0]              backdrop,
  input  logic [1:0]                      blend_mode,
  input  logic [NUM_LAYERS:0]             tgt1_mask,
  input  logic [NUM_LAYERS:0]             tgt2_mask,
  input  logic [4:0]                      eva,
  input  logic [4:0]                      evb,
  input  logic [4:0]                      evy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COLOR_W-1:0]              out_color,
  output logic                            out_last
);

  localparam int CH_W  = COLOR_W / 3;
  localparam int IDX_W = $clog2(NUM_LAYERS + 1);
  localparam int X_W   = $clog2(LINE_WIDTH);
  localparam int P_W   = CH_W + 5;
  localparam logic [CH_W-1:0]  CHMAX  = '1;
  localparam logic [IDX_W-1:0] BD_IDX = IDX_W'(NUM_LAYERS);
  localparam logic [X_W-1:0]   X_LAST = X_W'(LINE_WIDTH - 1);

  typedef enum logic [1:0] {BK_FREE, BK_FILLING, BK_FULL, BK_DRAINING} bank_state_e;
  typedef enum logic [1:0] {FX_NONE, FX_ALPHA, FX_BRIGHT, FX_DARK} fx_e;

  function automatic logic [4:0] clamp16(input logic [4:0] v);
    return (v > 5'd16) ? 5'd16 : v;
  endfunction

  // write side
  logic [X_W-1:0] wr_x;
  logic           wr_bank;
  logic           accept;
  logic           first_beat;
  bank_state_e    bank_st [2];

  // per-line latched configuration
  logic [1:0]          cfg_mode;
  logic [NUM_LAYERS:0] cfg_t1, cfg_t2;
  logic [4:0]          cfg_eva, cfg_evb, cfg_evy;
  logic [1:0]          u_mode;
  logic [NUM_LAYERS:0] u_t1, u_t2;
  logic [4:0]          u_eva, u_evb, u_evy;

  // selection results
  logic               top_found, sec_found;
  logic [1:0]         top_prio, sec_prio;
  logic [IDX_W-1:0]   top_idx, sec_idx;
  logic [COLOR_W-1:0] top_col, sec_col;
  fx_e                fx_sel;
  logic [4:0]         k_a, k_b;

  // pipeline registers
  logic               s1_v, s2_v, s3_v;
  fx_e                s1_fx, s2_fx;
  logic [COLOR_W-1:0] s1_c1, s1_c2, s2_c1, s3_color;
  logic [4:0]         s1_ka, s1_kb;
  logic               s1_bank, s2_bank, s3_bank;
  logic [X_W-1:0]     s1_x, s2_x, s3_x;
  logic [2:0][P_W-1:0] s2_p1, s2_p2, p1_next, p2_next;
  logic [COLOR_W-1:0] s3_next;

  // line buffer and read side
  logic [COLOR_W-1:0] line_mem [2][LINE_WIDTH];
  logic               rd_bank, out_bank;
  logic [X_W-1:0]     rd_x;
  logic               fetch_ok, load, out_hs;

  assign first_beat = (wr_x == '0);
  // Mid-line the target bank is our own FILLING bank; only a line start needs a FREE bank.
  assign in_ready   = rst_b && (!first_beat || bank_st[wr_bank] == BK_FREE);
  assign accept     = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;
  assign fetch_ok   = (bank_st[rd_bank] == BK_FULL) || (bank_st[rd_bank] == BK_DRAINING);
  assign load       = fetch_ok && (!out_valid || out_ready);

  // Config seen by the current beat: live inputs at pixel 0, latched copy afterwards.
  always_comb begin
    u_mode = first_beat ? blend_mode : cfg_mode;
    u_t1   = first_beat ? tgt1_mask  : cfg_t1;
    u_t2   = first_beat ? tgt2_mask  : cfg_t2;
    u_eva  = first_beat ? eva        : cfg_eva;
    u_evb  = first_beat ? evb        : cfg_evb;
    u_evy  = first_beat ? evy        : cfg_evy;
  end

  // Stage-1 selection: lowest prio wins, ties to lowest index, backdrop as fallback.
  always_comb begin
    top_found = 1'b0;
    top_prio  = '0;
    top_idx   = BD_IDX;
    top_col   = backdrop;
    sec_found = 1'b0;
    sec_prio  = '0;
    sec_idx   = BD_IDX;
    sec_col   = backdrop;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (layer_opaque[i] && (!top_found || layer_prio[2*i +: 2] < top_prio)) begin
        top_found = 1'b1;
        top_prio  = layer_prio[2*i +: 2];
        top_idx   = IDX_W'(i);
        top_col   = layer_color[i*COLOR_W +: COLOR_W];
      end
    end
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (layer_opaque[i] && (IDX_W'(i) != top_idx) &&
          (!sec_found || layer_prio[2*i +: 2] < sec_prio)) begin
        sec_found = 1'b1;
        sec_prio  = layer_prio[2*i +: 2];
        sec_idx   = IDX_W'(i);
        sec_col   = layer_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  // Effect decision and clamped coefficients for the current beat.
  always_comb begin
    fx_sel = FX_NONE;
    case (u_mode)
      2'b01:   if (u_t1[top_idx] && u_t2[sec_idx]) fx_sel = FX_ALPHA;
      2'b10:   if (u_t1[top_idx]) fx_sel = FX_BRIGHT;
      2'b11:   if (u_t1[top_idx]) fx_sel = FX_DARK;
      default: fx_sel = FX_NONE;
    endcase
    k_a = (u_mode == 2'b01) ? clamp16(u_eva) : clamp16(u_evy);
    k_b = clamp16(u_evb);
  end

  // Stage-2 products at full width.
  always_comb begin
    logic [CH_W-1:0] c1ch, c2ch, base;
    c1ch    = '0;
    c2ch    = '0;
    base    = '0;
    p1_next = '0;
    p2_next = '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      c1ch = s1_c1[ch*CH_W +: CH_W];
      c2ch = s1_c2[ch*CH_W +: CH_W];
      base = (s1_fx == FX_BRIGHT) ? (CHMAX - c1ch) : c1ch;
      p1_next[ch] = P_W'(base) * P_W'(s1_ka);
      p2_next[ch] = P_W'(c2ch) * P_W'(s1_kb);
    end
  end

  // Stage-3 shift, saturate and apply.
  always_comb begin
    logic [P_W:0]    sum, sh;
    logic [P_W-1:0]  q;
    logic [CH_W-1:0] c1ch;
    sum     = '0;
    sh      = '0;
    q       = '0;
    c1ch    = '0;
    s3_next = '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      c1ch = s2_c1[ch*CH_W +: CH_W];
      sum  = (P_W+1)'(s2_p1[ch]) + (P_W+1)'(s2_p2[ch]);
      sh   = sum >> 4;
      q    = s2_p1[ch] >> 4;
      case (s2_fx)
        FX_ALPHA:  s3_next[ch*CH_W +: CH_W] = (sh > (P_W+1)'(CHMAX)) ? CHMAX : sh[CH_W-1:0];
        FX_BRIGHT: s3_next[ch*CH_W +: CH_W] = c1ch + q[CH_W-1:0];
        FX_DARK:   s3_next[ch*CH_W +: CH_W] = c1ch - q[CH_W-1:0];
        default:   s3_next[ch*CH_W +: CH_W] = c1ch;
      endcase
    end
  end

  // Beat counter, write-bank toggle and per-line config latch.
  always_ff @(posedge clock) begin
    if (!rst_b) begin
      wr_x     <= '0;
      wr_bank  <= 1'b0;
      cfg_mode <= '0;
      cfg_t1   <= '0;
      cfg_t2   <= '0;
      cfg_eva  <= '0;
      cfg_evb  <= '0;
      cfg_evy  <= '0;
    end else if (accept) begin
      if (first_beat) begin
        cfg_mode <= blend_mode;
        cfg_t1   <= tgt1_mask;
        cfg_t2   <= tgt2_mask;
        cfg_eva  <= eva;
        cfg_evb  <= evb;
        cfg_evy  <= evy;
      end
      if (wr_x == X_LAST) begin
        wr_x    <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_x <= wr_x + 1'b1;
      end
    end
  end

  // Three-stage non-stalling effect pipeline.
  always_ff @(posedge clock) begin
    if (!rst_b) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s3_v <= 1'b0;
      s1_fx <= FX_NONE; s2_fx <= FX_NONE;
      s1_c1 <= '0; s1_c2 <= '0; s1_ka <= '0; s1_kb <= '0;
      s1_bank <= 1'b0; s2_bank <= 1'b0; s3_bank <= 1'b0;
      s1_x <= '0; s2_x <= '0; s3_x <= '0;
      s2_c1 <= '0; s2_p1 <= '0; s2_p2 <= '0; s3_color <= '0;
    end else begin
      s1_v     <= accept;
      s1_fx    <= fx_sel;
      s1_c1    <= top_col;
      s1_c2    <= sec_col;
      s1_ka    <= k_a;
      s1_kb    <= k_b;
      s1_bank  <= wr_bank;
      s1_x     <= wr_x;
      s2_v     <= s1_v;
      s2_fx    <= s1_fx;
      s2_c1    <= s1_c1;
      s2_p1    <= p1_next;
      s2_p2    <= p2_next;
      s2_bank  <= s1_bank;
      s2_x     <= s1_x;
      s3_v     <= s2_v;
      s3_color <= s3_next;
      s3_bank  <= s2_bank;
      s3_x     <= s2_x;
    end
  end

  // Line buffer write port.
  always_ff @(posedge clock) begin
    if (s3_v) line_mem[s3_bank][s3_x] <= s3_color;
  end

  // Bank lifecycle: FREE -> FILLING -> FULL -> DRAINING -> FREE.
  always_ff @(posedge clock) begin
    if (!rst_b) begin
      bank_st[0] <= BK_FREE;
      bank_st[1] <= BK_FREE;
    end else begin
      if (accept && first_beat) bank_st[wr_bank] <= BK_FILLING;
      if (s3_v && s3_x == X_LAST) bank_st[s3_bank] <= BK_FULL;
      if (out_hs) begin
        if (out_last)                          bank_st[out_bank] <= BK_FREE;
        else if (bank_st[out_bank] == BK_FULL) bank_st[out_bank] <= BK_DRAINING;
      end
    end
  end

  // Read side: the fetch pointer moves to the next bank as soon as a line's last
  // pixel enters the output register, so consecutive FULL banks drain gaplessly.
  always_ff @(posedge clock) begin
    if (!rst_b) begin
      rd_bank   <= 1'b0;
      rd_x      <= '0;
      out_bank  <= 1'b0;
      out_valid <= 1'b0;
      out_color <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_color <= line_mem[rd_bank][rd_x];
      out_last  <= (rd_x == X_LAST);
      out_bank  <= rd_bank;
      if (rd_x == X_LAST) begin
        rd_x    <= '0;
        rd_bank <= ~rd_bank;
      end else begin
        rd_x <= rd_x + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
